// File: rtl/subleq_pkg.sv
// Shared definitions for the subleq memory responder: FSM encoding and default widths.
package subleq_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned TXN_W          = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : subleq_pkg

// File: rtl/subleq_ram.sv
// Single-port word RAM: synchronous write, registered read; the read register can be cleared.
module subleq_ram
    import subleq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array is deliberately not reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register returns zero for writes and rejected accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (clr_i || (en_i && we_i)) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : subleq_ram

// File: rtl/subleq_mem_responder.sv
// Valid/ready memory responder: one outstanding request, fixed response latency,
// out-of-range error reporting and a completed-response counter.
module subleq_mem_responder
    import subleq_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_USED = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [TXN_W-1:0]  txn_count
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH_USED);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TXN_W-1:0]   txn_q, txn_d;
    logic               req_ready_q, rsp_valid_q, rsp_err_q;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic               hs;
    logic               enter_resp;
    logic               act_write;
    logic [ADDR_W-1:0]  act_addr;
    logic [DATA_W-1:0]  act_wdata;
    logic               in_range;

    assign hs = req_valid && req_ready_q;

    // With LATENCY=1 the access happens on the handshake edge, before the latch is visible.
    assign act_write  = (state_q == IDLE) ? req_write : write_q;
    assign act_addr   = (state_q == IDLE) ? req_addr  : addr_q;
    assign act_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
    assign in_range   = {1'b0, act_addr} < DEPTH_LIM;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // Next-state, wait counter and completion counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        txn_d   = txn_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    txn_d   = txn_q + TXN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            txn_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txn_q       <= txn_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            if (hs) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rsp_err_q <= !in_range;
            end
        end
    end

    subleq_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH_USED)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (enter_resp && in_range),
        .we_i    (act_write),
        .clr_i   (enter_resp && !in_range),
        .addr_i  (act_addr),
        .wdata_i (act_wdata),
        .rdata_o (rsp_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_q;

endmodule : subleq_mem_responder

// File: tb/tb_subleq_mem_responder.sv
// Bench for subleq_mem_responder: instance 0 at LATENCY=2, instance 1 at LATENCY=1,
// instance 2 at LATENCY=15, all checked against a word-level memory model.
module tb_subleq_mem_responder;

    localparam int DEPTH = 200;

    logic clk;
    logic [2:0]       rstn, rv, rw, rr;
    logic [2:0][7:0]  ra;
    logic [2:0][63:0] wd;
    logic [2:0]       qr, sv, se;
    logic [2:0][63:0] rd;
    logic [2:0][15:0] tc;

    int               lat_of [3] = '{2, 1, 15};
    logic [63:0]      mdl   [3][256];
    bit               known [3][256];
    logic [15:0]      exp_tc [3];
    int               n_chk = 0;
    int               n_err = 0;

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [63:0] d;
        logic [63:0] exp_rd;
        bit          exp_err;
        int          hold;
    } vec_t;

    vec_t tbl [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    subleq_mem_responder #(.LATENCY(2)) dut0 (
        .clk(clk), .rst(rstn[0]), .req_valid(rv[0]), .req_ready(qr[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(wd[0]), .rsp_valid(sv[0]), .rsp_ready(rr[0]),
        .rsp_rdata(rd[0]), .rsp_err(se[0]), .txn_count(tc[0]));

    subleq_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rstn[1]), .req_valid(rv[1]), .req_ready(qr[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(wd[1]), .rsp_valid(sv[1]), .rsp_ready(rr[1]),
        .rsp_rdata(rd[1]), .rsp_err(se[1]), .txn_count(tc[1]));

    subleq_mem_responder #(.LATENCY(15)) dut2 (
        .clk(clk), .rst(rstn[2]), .req_valid(rv[2]), .req_ready(qr[2]), .req_write(rw[2]),
        .req_addr(ra[2]), .req_wdata(wd[2]), .rsp_valid(sv[2]), .rsp_ready(rr[2]),
        .rsp_rdata(rd[2]), .rsp_err(se[2]), .txn_count(tc[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // One complete transaction on instance i, checked against the model.
    task automatic do_txn(input int i, input bit w, input logic [7:0] a, input logic [63:0] d,
                          input int hold, output logic [63:0] got_rd, output bit got_err);
        logic [63:0] er;
        bit          ee, chkd;
        int          n;
        logic [15:0] tc0;
        ee     = (int'(a) >= DEPTH);
        er     = '0;
        chkd   = 1'b1;
        got_rd = '0;
        got_err = 1'b0;
        if (!ee && !w) begin
            er   = mdl[i][a];
            chkd = known[i][a];
        end
        @(negedge clk);
        rv[i] = 1'b1; rw[i] = w; ra[i] = a; wd[i] = d; rr[i] = 1'b0;
        n = 0;
        while (!qr[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            timeout($sformatf("req_ready i%0d", i));
            rv[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rv[i] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sv[i] && n < 40);
        if (!sv[i]) begin
            timeout($sformatf("rsp_valid i%0d", i));
            return;
        end
        chk($sformatf("latency i%0d a%0d", i, a), 64'(n), 64'(lat_of[i]));
        if (!ee && w) begin
            mdl[i][a]   = d;
            known[i][a] = 1'b1;
        end
        got_rd  = rd[i];
        got_err = se[i];
        tc0     = tc[i];
        if (chkd) chk($sformatf("rdata i%0d a%0d", i, a), got_rd, er);
        chk($sformatf("err i%0d a%0d", i, a), 64'(got_err), 64'(ee));
        chk($sformatf("txn_count before i%0d", i), 64'(tc0), 64'(exp_tc[i]));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold rsp_valid", 64'(sv[i]), 64'd1);
            chk("hold rdata", rd[i], got_rd);
            chk("hold err", 64'(se[i]), 64'(got_err));
            chk("hold req_ready", 64'(qr[i]), 64'd0);
            chk("hold txn_count", 64'(tc[i]), 64'(tc0));
        end
        rr[i] = 1'b1;
        @(posedge clk);
        #1 rr[i] = 1'b0;
        exp_tc[i] = exp_tc[i] + 16'd1;
        @(negedge clk);
        chk($sformatf("rsp_valid drop i%0d", i), 64'(sv[i]), 64'd0);
        chk($sformatf("txn_count after i%0d", i), 64'(tc[i]), 64'(exp_tc[i]));
    endtask

    initial begin
        logic [63:0] g_rd;
        bit          g_err;
        int          n;

        rstn = '0; rv = '0; rw = '0; rr = '0; ra = '0; wd = '0;
        for (int i = 0; i < 3; i++) begin
            exp_tc[i] = '0;
            for (int j = 0; j < 256; j++) known[i][j] = 1'b0;
        end

        tbl.push_back('{1'b1, 8'd250, 64'hFF,                 64'h0,                 1'b1, 0});
        tbl.push_back('{1'b0, 8'd250, 64'h0,                  64'h0,                 1'b1, 0});
        tbl.push_back('{1'b1, 8'd5,   64'h2A,                 64'h0,                 1'b0, 0});
        tbl.push_back('{1'b0, 8'd5,   64'h0,                  64'h2A,                1'b0, 5});
        tbl.push_back('{1'b1, 8'd199, 64'hDEAD_BEEF_0000_0199, 64'h0,                1'b0, 0});
        tbl.push_back('{1'b0, 8'd199, 64'h0,                  64'hDEAD_BEEF_0000_0199, 1'b0, 0});
        tbl.push_back('{1'b1, 8'd200, 64'h1,                  64'h0,                 1'b1, 0});
        tbl.push_back('{1'b0, 8'd200, 64'h0,                  64'h0,                 1'b1, 3});
        tbl.push_back('{1'b1, 8'd0,   64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                1'b0, 0});
        tbl.push_back('{1'b0, 8'd0,   64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1});
        tbl.push_back('{1'b1, 8'd5,   64'h77,                 64'h0,                 1'b0, 0});
        tbl.push_back('{1'b0, 8'd5,   64'h0,                  64'h77,                1'b0, 0});
        tbl.push_back('{1'b0, 8'd255, 64'h0,                  64'h0,                 1'b1, 2});

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset req_ready i%0d", i), 64'(qr[i]), 64'd0);
            chk($sformatf("reset rsp_valid i%0d", i), 64'(sv[i]), 64'd0);
            chk($sformatf("reset rdata i%0d", i), rd[i], 64'd0);
            chk($sformatf("reset err i%0d", i), 64'(se[i]), 64'd0);
            chk($sformatf("reset txn_count i%0d", i), 64'(tc[i]), 64'd0);
        end
        rstn = '1;
        @(posedge clk);
        #1;
        chk("req_ready first edge", 64'(qr[0]), 64'd1);

        // Directed table on the LATENCY=2 instance
        foreach (tbl[k]) begin
            do_txn(0, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].hold, g_rd, g_err);
            chk($sformatf("table rdata %0d", k), g_rd, tbl[k].exp_rd);
            chk($sformatf("table err %0d", k), 64'(g_err), 64'(tbl[k].exp_err));
            if (k == 1) chk("txn_count after out-of-range pair", 64'(tc[0]), 64'd2);
        end

        // Reset while a write is waiting: the write must be dropped
        do_txn(0, 1'b1, 8'd7, 64'h1234, 0, g_rd, g_err);
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'd7; wd[0] = 64'h55;
        n = 0;
        while (!qr[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("req_ready before reset");
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b0;
        #1;
        chk("mid reset rsp_valid", 64'(sv[0]), 64'd0);
        chk("mid reset txn_count", 64'(tc[0]), 64'd0);
        chk("mid reset req_ready", 64'(qr[0]), 64'd0);
        exp_tc[0] = '0;
        repeat (2) @(negedge clk);
        rstn[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready after reset", 64'(qr[0]), 64'd1);
        do_txn(0, 1'b0, 8'd7, 64'h0, 0, g_rd, g_err);
        chk("read after dropped write", g_rd, 64'h1234);

        // Randomized traffic against the model
        for (int k = 0; k < 150; k++) begin
            do_txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   {$urandom, $urandom}, $urandom_range(0, 2), g_rd, g_err);
        end

        // Latency extremes
        for (int i = 1; i < 3; i++) begin
            do_txn(i, 1'b0, 8'd0, 64'h0, 0, g_rd, g_err);
            do_txn(i, 1'b0, 8'd1, 64'h0, 0, g_rd, g_err);
        end

        // Counter wrap: stream reads through the LATENCY=1 instance up to 16'hFFFF
        @(negedge clk);
        rw[1] = 1'b0; ra[1] = 8'd0; rv[1] = 1'b1; rr[1] = 1'b1;
        n = 0;
        while (tc[1] != 16'hFFFF && n < 140000) begin
            @(negedge clk);
            n++;
        end
        rv[1] = 1'b0;
        rr[1] = 1'b0;
        if (n >= 140000) timeout("txn_count preload");
        @(negedge clk);
        chk("txn_count preload", 64'(tc[1]), 64'hFFFF);
        exp_tc[1] = 16'hFFFF;
        do_txn(1, 1'b0, 8'd3, 64'h0, 0, g_rd, g_err);
        chk("txn_count wrap", 64'(tc[1]), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_subleq_mem_responder
